// File: rtl/collector_pkg.sv
// Shared types and width helpers for the serial word collector.
package collector_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_e;

    localparam int WORD_W = 4;
    localparam int FIFO_D = 2;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int BIT_CNT_W = cnt_w(WORD_W);
    localparam int PTR_W     = ptr_w(FIFO_D);
    localparam int FCNT_W    = cnt_w(FIFO_D);

endpackage

// File: rtl/word_fifo.sv
// Small FIFO with a registered head view; drops pushes when full unless
// a pop on the same edge frees a slot.
module word_fifo
    import collector_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = FIFO_D
) (
    input  logic             c,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             not_empty,
    output logic             full
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    rd_q, rd_d;
    logic [PW-1:0]    wr_q, wr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push;
    logic             do_pop;

    assign not_empty = (cnt_q != '0);
    assign full      = (cnt_q == CNT_FULL);
    assign head_data = head_q;

    always_comb begin
        do_pop  = pop & not_empty;
        do_push = push & (~full | do_pop);
        mem_d   = mem_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        if (do_push) begin
            mem_d[wr_q] = push_data;
            wr_d        = wr_q + PW'(1);
        end
        if (do_pop) begin
            rd_d = rd_q + PW'(1);
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - CW'(1);
        end
        // Head follows the post-update read slot; holds when empty.
        head_d = (cnt_d != '0) ? mem_d[rd_d] : head_q;
    end

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            head_q <= '0;
        end else begin
            mem_q  <= mem_d;
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            head_q <= head_d;
        end
    end

endmodule

// File: rtl/serial_word_collector.sv
// Reassembles MSB-first serial bits into WIDTH-bit words and buffers
// them for a valid/ready consumer.
module serial_word_collector
    import collector_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = FIFO_D
) (
    input  logic                       c,
    input  logic                       rst_n,
    input  logic                       sin,
    input  logic                       sin_valid,
    input  logic                       sof,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       overflow,
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-2:0] acc_q, acc_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] word_w;
    logic             push;
    logic             pop;
    logic             fifo_full;

    assign word_w   = {acc_q, sin};
    assign pop      = out_valid & out_ready;
    assign bit_cnt  = cnt_q;
    assign overflow = overflow_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        push    = 1'b0;
        if (sin_valid) begin
            if (sof) begin
                // A frame start restarts the word; pending bits vanish.
                acc_d    = '0;
                acc_d[0] = sin;
                cnt_d    = CW'(1);
                state_d  = COLLECT;
            end else if (state_q == COLLECT && cnt_q == LAST) begin
                acc_d   = word_w[WIDTH-2:0];
                push    = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end else begin
                acc_d   = word_w[WIDTH-2:0];
                cnt_d   = cnt_q + CW'(1);
                state_d = COLLECT;
            end
        end
        overflow_d = overflow_q | (push & fifo_full & ~pop);
    end

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            overflow_q <= overflow_d;
        end
    end

    word_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .c         (c),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (word_w),
        .pop       (pop),
        .head_data (out_data),
        .not_empty (out_valid),
        .full      (fifo_full)
    );

endmodule

// File: doc/serial_word_collector.md
Name: serial_word_collector

Overview:
- Downstream stage of the 4-bit parallel-load, left-shifting shift register.
- Samples that register's serial MSB output (q[3]) one bit per qualified clock and reassembles MSB-first words of WIDTH bits.
- Completed words are buffered in a small FIFO and presented to the next consumer over a valid/ready handshake.

Parameters:
- WIDTH, 4, bits per assembled word; must be >= 2.
- DEPTH, 2, output FIFO entries; a power of two, >= 2.

Ports:
- c  input  1  clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- sin  input  1  serial data bit, taken from upstream q[3].
- sin_valid  input  1  sin is sampled on this edge.
- sof  input  1  start-of-frame; meaningful only with sin_valid; marks sin as bit 0 (the MSB) of a new word.
- out_data  output  WIDTH  head-of-FIFO word.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts out_data on this edge when out_valid=1.
- overflow  output  1  sticky; a completed word was dropped.
- bit_cnt  output  $clog2(WIDTH+1)  bits held in the partial word.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; bit_cnt=0; shift accumulator=0.
  - FIFO emptied: pointers=0, count=0.
  - out_valid=0; out_data=0; overflow=0.
  - Takes effect immediately, including mid-word or mid-handshake; any partial word and all buffered words are lost.
- States:
  - IDLE: no partial word.
  - COLLECT: 1..WIDTH-1 bits held.
- Bit capture:
  - Each edge with sin_valid=1: acc <= {acc[WIDTH-2:0], sin}; bit_cnt increments.
  - The first bit received lands in the MSB. Upstream value 4'b0011 shifted out as 0,0,1,1 reassembles to 4'b0011.
- sin_valid=0: acc, bit_cnt and state hold; there is no timeout.
- Transitions:
  - IDLE -> COLLECT on sin_valid (bit_cnt=1).
  - COLLECT -> IDLE on the edge accepting bit WIDTH.
- Word completion:
  - The edge accepting bit WIDTH pushes {acc[WIDTH-2:0], sin} into the FIFO.
  - On that edge bit_cnt returns to 0.
  - out_valid rises on the following cycle if the FIFO was empty (1-cycle latency, last bit to out_valid).
- sof with sin_valid:
  - Any partial word is discarded without error.
  - sin becomes bit 0 of a new word; bit_cnt=1; state=COLLECT.
  - With WIDTH bits already pending, none are pushed.
  - sof with sin_valid=0 is ignored.
- FIFO and handshake:
  - out_data/out_valid are registered views of the head entry.
  - A pop occurs when out_valid & out_ready.
  - While out_valid=1 and out_ready=0, out_data holds stable.
  - Pointers wrap modulo DEPTH.
  - When the FIFO is empty, out_data holds its last value; it is don't-care to consumers.
- Full boundary:
  - A push and a pop on the same edge while full: both succeed, count unchanged, no overflow.
  - A push while full without a pop: the new word is dropped, the FIFO is unchanged, overflow <= 1.
  - overflow clears only on reset.
- Empty boundary:
  - A push and a pop on the same edge while empty cannot occur, because out_valid=0.
  - The push alone proceeds.
- Width rules:
  - bit_cnt never exceeds WIDTH-1 when observed.
  - FIFO count is $clog2(DEPTH+1) bits.

Decomposition:
- Shared package (collector_pkg):
  - State enum {IDLE, COLLECT}.
  - Default constants WORD_W=4, FIFO_D=2.
  - Width helper localparams for the counter and pointers.
- One natural sub-module: word_fifo.
  - Parameters WIDTH and DEPTH.
  - Ports: push, push_data, pop, head_data, not_empty, full; async active-low reset.
  - The top holds the FSM, bit counter, accumulator and overflow logic.

Test Plan:
- Upstream shift register loaded with 4'b0011 then shifting; sin_valid=1 for 4 edges, sin=0,0,1,1, out_ready=1 -> out_valid=1 one cycle after the 4th edge with out_data=4'b0011; overflow=0.
- Bits 1,0,1; sof=1 with sin=1; then 1,0,0 -> partial 101 discarded; single word 4'b1100 emitted; bit_cnt reads 3,1,2,3,0 across those edges.
- out_ready=0; three words 4'hA, 4'h5, 4'hF sent -> out_valid=1, out_data=4'hA held, 4'hF dropped, overflow=1; then out_ready=1 -> pops 4'hA then 4'h5; overflow stays 1.
- FIFO full (4'h1, 4'h2); 4th bit of 4'h3 arrives on the same edge out_ready=1 pops 4'h1 -> no overflow; subsequent outputs 4'h2 then 4'h3.
- Mid-word (bit_cnt=2), FIFO holding one word, rst_n pulsed low between edges -> out_valid, bit_cnt and overflow fall to 0 immediately; next 4 bits 0,1,1,0 yield 4'b0110.
- sin_valid toggled 1,0,0,1,0,1,1 with sin=1,x,x,0,x,0,1 -> only valid bits counted; word 4'b1001 emitted after the 7th edge.
